// File: rtl/msg_tx_framer.sv
// Transmit framer: turns message requests plus a payload word stream into head/data/tail beats.
// Define MSG_TX_PARITY_EN to add the registered even-parity output out_parity.
module msg_tx_framer #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [LEN_W-1:0]  req_len,
    output logic              req_ready,
    input  logic              pl_valid,
    input  logic [DATA_W-1:0] pl_data,
    output logic              pl_ready,
    output logic              out_valid,
    output logic              out_head,
    output logic              out_tail,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              msg_ip
`ifdef MSG_TX_PARITY_EN
    ,
    output logic              out_parity
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HEAD = 2'b01,
        DATA = 2'b10,
        TAIL = 2'b11
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [LEN_W-1:0]   cnt;
    logic [LEN_W-1:0]   cnt_next;
    logic               slot;
    logic               fire;
    logic               req_accept;
    logic               beat_head;
    logic               beat_tail;

    // The output register can take a new beat when empty or draining this cycle.
    assign slot       = !out_valid || out_ready;
    assign pl_ready   = (state != IDLE) && slot;
    assign fire       = pl_valid && pl_ready;
    assign req_ready  = (state == IDLE) || ((state == TAIL) && fire);
    assign req_accept = req_valid && req_ready;
    assign msg_ip     = (state != IDLE) || out_valid;
    assign beat_head  = (state == HEAD);
    assign beat_tail  = (state == TAIL);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (req_accept) begin
            cnt_next = req_len;
        end
        unique case (state)
            IDLE: begin
                if (req_accept) state_next = HEAD;
            end
            HEAD: begin
                if (fire) state_next = (cnt != '0) ? DATA : TAIL;
            end
            DATA: begin
                if (fire) begin
                    if (cnt != '0) cnt_next = cnt - LEN_W'(1);
                    if (cnt == LEN_W'(1)) state_next = TAIL;
                end
            end
            TAIL: begin
                if (fire) state_next = req_accept ? HEAD : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Beat register: everything stays frozen while a beat is stalled by the link.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_head  <= 1'b0;
            out_tail  <= 1'b0;
            out_data  <= '0;
        end else if (fire) begin
            out_valid <= 1'b1;
            out_head  <= beat_head;
            out_tail  <= beat_tail;
            out_data  <= pl_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef MSG_TX_PARITY_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            out_parity <= 1'b0;
        end else if (fire) begin
            out_parity <= ^{beat_head, beat_tail, pl_data};
        end
    end
`endif

endmodule

// File: tb/tb_msg_tx_framer.sv
// Directed self-checking bench for msg_tx_framer; beats are captured on the falling edge.
// The parity scenario is compiled only when MSG_TX_PARITY_EN is defined.
module tb_msg_tx_framer;

    logic       clock;
    logic       reset;
    logic       req_valid;
    logic [3:0] req_len;
    logic       req_ready;
    logic       pl_valid;
    logic [7:0] pl_data;
    logic       pl_ready;
    logic       out_valid;
    logic       out_head;
    logic       out_tail;
    logic [7:0] out_data;
    logic       out_ready;
    logic       msg_ip;
`ifdef MSG_TX_PARITY_EN
    logic       out_parity;
`endif

    typedef struct {
        logic       head;
        logic       tail;
        logic [7:0] data;
        int         cyc;
    } beat_t;

    beat_t      beats[$];
    logic [7:0] src[$];
    logic [3:0] reqs[$];
    int         src_idx = 0;
    int         cycle = 0;
    int         n_cmp = 0;
    int         n_fail = 0;

    msg_tx_framer #(.DATA_W(8), .LEN_W(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_len   (req_len),
        .req_ready (req_ready),
        .pl_valid  (pl_valid),
        .pl_data   (pl_data),
        .pl_ready  (pl_ready),
        .out_valid (out_valid),
        .out_head  (out_head),
        .out_tail  (out_tail),
        .out_data  (out_data),
        .out_ready (out_ready),
        .msg_ip    (msg_ip)
`ifdef MSG_TX_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cycle++;

    always @(negedge clock) begin
        if (out_valid === 1'b1 && out_ready === 1'b1)
            beats.push_back('{out_head, out_tail, out_data, cycle});
    end

    // One clock cycle: drive source/request/link, note handshakes, advance the source models.
    task automatic step(input logic pv, input logic ordy);
        logic fired;
        logic accepted;
        pl_valid  = pv && (src_idx < src.size());
        pl_data   = (src_idx < src.size()) ? src[src_idx] : 8'h00;
        out_ready = ordy;
        req_valid = (reqs.size() > 0);
        req_len   = (reqs.size() > 0) ? reqs[0] : 4'd0;
        @(negedge clock);
        fired    = pl_valid && pl_ready;
        accepted = req_valid && req_ready;
        @(posedge clock);
        #1;
        if (fired) src_idx++;
        if (accepted) void'(reqs.pop_front());
    endtask

    task automatic new_scenario();
        beats.delete();
        src.delete();
        reqs.delete();
        src_idx = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = 1'b0;
        req_len = 4'd0;
        pl_valid = 1'b0;
        pl_data = 8'h00;
        out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_head !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_head: got %b want 0", out_head); end
        n_cmp++; if (out_tail !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_tail: got %b want 0", out_tail); end
        n_cmp++; if (out_data !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_out_data: got %h want 00", out_data); end
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_req_ready: got %b want 1", req_ready); end
        n_cmp++; if (pl_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_pl_ready: got %b want 0", pl_ready); end
        n_cmp++; if (msg_ip !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_msg_ip: got %b want 0", msg_ip); end
    endtask

    task automatic test_basic_len2();
        logic [9:0] exp[4] = '{{2'b10, 8'hA0}, {2'b00, 8'hA1}, {2'b00, 8'hA2}, {2'b01, 8'hA3}};
        new_scenario();
        src = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        reqs = '{4'd2};
        repeat (8) step(1'b1, 1'b1);
        n_cmp++; if (beats.size() !== 4) begin n_fail++; $display("[TB] FAIL len2_count: got %0d want 4", beats.size()); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (i >= beats.size()) begin
                n_fail++; $display("[TB] FAIL len2_beat%0d: got none want %h", i, exp[i]);
            end else if ({beats[i].head, beats[i].tail, beats[i].data} !== exp[i]) begin
                n_fail++; $display("[TB] FAIL len2_beat%0d: got %h want %h", i, {beats[i].head, beats[i].tail, beats[i].data}, exp[i]);
            end
        end
        n_cmp++; if (beats.size() == 4 && beats[3].cyc - beats[0].cyc !== 3) begin n_fail++; $display("[TB] FAIL len2_spacing: got %0d cycles want 3", beats[3].cyc - beats[0].cyc); end
        n_cmp++; if (msg_ip !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL len2_idle_after: got msg_ip=%b req_ready=%b want 0/1", msg_ip, req_ready); end
    endtask

    task automatic test_len0();
        logic [9:0] exp[2] = '{{2'b10, 8'h5A}, {2'b01, 8'hC3}};
        new_scenario();
        src = '{8'h5A, 8'hC3};
        reqs = '{4'd0};
        repeat (6) step(1'b1, 1'b1);
        n_cmp++; if (beats.size() !== 2) begin n_fail++; $display("[TB] FAIL len0_count: got %0d want 2", beats.size()); end
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (i >= beats.size()) begin
                n_fail++; $display("[TB] FAIL len0_beat%0d: got none want %h", i, exp[i]);
            end else if ({beats[i].head, beats[i].tail, beats[i].data} !== exp[i]) begin
                n_fail++; $display("[TB] FAIL len0_beat%0d: got %h want %h", i, {beats[i].head, beats[i].tail, beats[i].data}, exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] exp[5] = '{{2'b10, 8'hB0}, {2'b00, 8'hB1}, {2'b01, 8'hB2}, {2'b10, 8'hC0}, {2'b01, 8'hC1}};
        new_scenario();
        src = '{8'hB0, 8'hB1, 8'hB2, 8'hC0, 8'hC1};
        reqs = '{4'd1, 4'd0};
        repeat (9) step(1'b1, 1'b1);
        n_cmp++; if (beats.size() !== 5) begin n_fail++; $display("[TB] FAIL b2b_count: got %0d want 5", beats.size()); end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (i >= beats.size()) begin
                n_fail++; $display("[TB] FAIL b2b_beat%0d: got none want %h", i, exp[i]);
            end else if ({beats[i].head, beats[i].tail, beats[i].data} !== exp[i]) begin
                n_fail++; $display("[TB] FAIL b2b_beat%0d: got %h want %h", i, {beats[i].head, beats[i].tail, beats[i].data}, exp[i]);
            end
        end
        n_cmp++; if (beats.size() == 5 && beats[4].cyc - beats[0].cyc !== 4) begin n_fail++; $display("[TB] FAIL b2b_no_bubble: got %0d cycles want 4", beats[4].cyc - beats[0].cyc); end
    endtask

    task automatic test_stall();
        logic [9:0] exp[5] = '{{2'b10, 8'hD0}, {2'b00, 8'hD1}, {2'b00, 8'hD2}, {2'b00, 8'hD3}, {2'b01, 8'hD4}};
        new_scenario();
        src = '{8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hD4};
        reqs = '{4'd3};
        for (int k = 0; k < 12; k++) begin
            step((k == 5) ? 1'b0 : 1'b1, (k == 3 || k == 4) ? 1'b0 : 1'b1);
            if (k == 3 || k == 4) begin
                n_cmp++;
                if ({out_valid, out_head, out_tail, out_data} !== {3'b100, 8'hD1}) begin
                    n_fail++; $display("[TB] FAIL stall_hold_k%0d: got %h want %h", k, {out_valid, out_head, out_tail, out_data}, {3'b100, 8'hD1});
                end
            end
            if (k == 5) begin
                n_cmp++;
                if (out_valid !== 1'b0 || msg_ip !== 1'b1) begin
                    n_fail++; $display("[TB] FAIL stall_drain: got out_valid=%b msg_ip=%b want 0/1", out_valid, msg_ip);
                end
            end
        end
        n_cmp++; if (beats.size() !== 5) begin n_fail++; $display("[TB] FAIL stall_count: got %0d want 5", beats.size()); end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (i >= beats.size()) begin
                n_fail++; $display("[TB] FAIL stall_beat%0d: got none want %h", i, exp[i]);
            end else if ({beats[i].head, beats[i].tail, beats[i].data} !== exp[i]) begin
                n_fail++; $display("[TB] FAIL stall_beat%0d: got %h want %h", i, {beats[i].head, beats[i].tail, beats[i].data}, exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid_message();
        logic [9:0] exp[3] = '{{2'b10, 8'hF0}, {2'b00, 8'hF1}, {2'b01, 8'hF2}};
        new_scenario();
        src = '{8'hE0, 8'hE1, 8'hE2, 8'hE3, 8'hE4, 8'hE5, 8'hE6};
        reqs = '{4'd5};
        repeat (3) step(1'b1, 1'b1);
        reset = 1'b1;
        step(1'b1, 1'b1);
        reset = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (msg_ip !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL midreset_idle: got msg_ip=%b req_ready=%b want 0/1", msg_ip, req_ready); end
        repeat (3) step(1'b1, 1'b1);
        n_cmp++; if (beats.size() !== 2) begin n_fail++; $display("[TB] FAIL midreset_count: got %0d want 2", beats.size()); end
        n_cmp++;
        if (beats.size() >= 2 && (beats[0].tail !== 1'b0 || beats[1].tail !== 1'b0)) begin
            n_fail++; $display("[TB] FAIL midreset_no_tail: got tails %b%b want 00", beats[0].tail, beats[1].tail);
        end
        new_scenario();
        src = '{8'hF0, 8'hF1, 8'hF2};
        reqs = '{4'd1};
        repeat (7) step(1'b1, 1'b1);
        n_cmp++; if (beats.size() !== 3) begin n_fail++; $display("[TB] FAIL postreset_count: got %0d want 3", beats.size()); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (i >= beats.size()) begin
                n_fail++; $display("[TB] FAIL postreset_beat%0d: got none want %h", i, exp[i]);
            end else if ({beats[i].head, beats[i].tail, beats[i].data} !== exp[i]) begin
                n_fail++; $display("[TB] FAIL postreset_beat%0d: got %h want %h", i, {beats[i].head, beats[i].tail, beats[i].data}, exp[i]);
            end
        end
    endtask

`ifdef MSG_TX_PARITY_EN
    task automatic test_parity();
        new_scenario();
        src = '{8'h03, 8'h01};
        reqs = '{4'd0};
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        n_cmp++; if ({out_head, out_parity} !== 2'b11) begin n_fail++; $display("[TB] FAIL parity_head: got head=%b parity=%b want 1/1", out_head, out_parity); end
        step(1'b1, 1'b1);
        n_cmp++; if ({out_tail, out_parity} !== 2'b10) begin n_fail++; $display("[TB] FAIL parity_tail: got tail=%b parity=%b want 1/0", out_tail, out_parity); end
        repeat (2) step(1'b1, 1'b1);
    endtask
`endif

    initial begin
        test_reset();
        test_basic_len2();
        test_len0();
        test_back_to_back();
        test_stall();
        test_reset_mid_message();
`ifdef MSG_TX_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
